// File: rtl/cache_pkg.sv
// Shared constants and FSM state type for the direct-mapped write-through cache.
package cache_pkg;

  localparam int unsigned ADDR_W_DEF  = 6;
  localparam int unsigned DATA_W_DEF  = 8;
  localparam int unsigned INDEX_W_DEF = 3;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_COMPARE   = 3'd1,
    ST_MEM_READ  = 3'd2,
    ST_MEM_WRITE = 3'd3,
    ST_DONE      = 3'd4
  } state_t;

endpackage

// File: rtl/cache_array.sv
// Line storage: valid/tag/data per line, combinational read port, synchronous write port.
module cache_array #(
  parameter int unsigned INDEX_W = 3,
  parameter int unsigned TAG_W   = 3,
  parameter int unsigned DATA_W  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INDEX_W-1:0] i_rd_index,
  output logic               o_rd_valid_c,
  output logic [TAG_W-1:0]   o_rd_tag_c,
  output logic [DATA_W-1:0]  o_rd_data_c,
  input  logic               i_we,
  input  logic [INDEX_W-1:0] i_wr_index,
  input  logic [TAG_W-1:0]   i_wr_tag,
  input  logic [DATA_W-1:0]  i_wr_data
);

  localparam int unsigned DEPTH = 1 << INDEX_W;

  logic [DEPTH-1:0]  r_valid;
  logic [TAG_W-1:0]  r_tag  [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];

  // Only the valid bits are cleared; tag/data are qualified by valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= '0;
    end else if (i_we) begin
      r_valid[i_wr_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_tag[i_wr_index]  <= i_wr_tag;
      r_data[i_wr_index] <= i_wr_data;
    end
  end

  assign o_rd_valid_c = r_valid[i_rd_index];
  assign o_rd_tag_c   = r_tag[i_rd_index];
  assign o_rd_data_c  = r_data[i_rd_index];

endmodule

// File: rtl/cache_controller.sv
// Direct-mapped, write-through, no-write-allocate cache controller with a
// single-word line and a req/ack main-memory interface.
module cache_controller
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned INDEX_W = INDEX_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              RWB,
  input  logic [ADDR_W-1:0] Address,
  input  logic [DATA_W-1:0] Data,
  output logic              ready,
  output logic [DATA_W-1:0] MemSysOut,
  output logic              Hit,
  output logic [7:0]        hit_count,
  output logic              mem_req,
  output logic              mem_rwb,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  localparam int unsigned TAG_W = ADDR_W - INDEX_W;

  state_t              r_state;
  state_t              w_next_state;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_rwb;
  logic [DATA_W-1:0]   r_data;
  logic                r_wr_hit;

  logic [INDEX_W-1:0]  w_index;
  logic [TAG_W-1:0]    w_tag;
  logic                w_line_valid;
  logic [TAG_W-1:0]    w_line_tag;
  logic [DATA_W-1:0]   w_line_data;
  logic                w_hit;
  logic                w_we;
  logic [DATA_W-1:0]   w_wr_data;
  logic                w_done_hit;
  logic                w_load_out;
  logic [DATA_W-1:0]   w_out_data;

  assign w_index = r_addr[INDEX_W-1:0];
  assign w_tag   = r_addr[ADDR_W-1:INDEX_W];
  assign w_hit   = w_line_valid && (w_line_tag == w_tag);

  cache_array #(
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W),
    .DATA_W  (DATA_W)
  ) u_array (
    .clk          (clk),
    .reset        (reset),
    .i_rd_index   (w_index),
    .o_rd_valid_c (w_line_valid),
    .o_rd_tag_c   (w_line_tag),
    .o_rd_data_c  (w_line_data),
    .i_we         (w_we),
    .i_wr_index   (w_index),
    .i_wr_tag     (w_tag),
    .i_wr_data    (w_wr_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state plus array write and read-data load strobes.
  always_comb begin
    w_next_state = r_state;
    w_we         = 1'b0;
    w_wr_data    = r_data;
    w_done_hit   = 1'b0;
    w_load_out   = 1'b0;
    w_out_data   = w_line_data;
    case (r_state)
      ST_IDLE: begin
        if (req) w_next_state = ST_COMPARE;
      end
      ST_COMPARE: begin
        if (r_rwb) begin
          if (w_hit) begin
            w_next_state = ST_DONE;
            w_done_hit   = 1'b1;
            w_load_out   = 1'b1;
          end else begin
            w_next_state = ST_MEM_READ;
          end
        end else begin
          w_next_state = ST_MEM_WRITE;
          w_we         = w_hit;
        end
      end
      ST_MEM_READ: begin
        if (mem_ack) begin
          w_next_state = ST_DONE;
          w_we         = 1'b1;
          w_wr_data    = mem_rdata;
          w_load_out   = 1'b1;
          w_out_data   = mem_rdata;
        end
      end
      ST_MEM_WRITE: begin
        if (mem_ack) begin
          w_next_state = ST_DONE;
          w_done_hit   = r_wr_hit;
        end
      end
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr    <= '0;
      r_rwb     <= 1'b1;
      r_data    <= '0;
      r_wr_hit  <= 1'b0;
      ready     <= 1'b0;
      Hit       <= 1'b0;
      MemSysOut <= '0;
      hit_count <= '0;
      mem_req   <= 1'b0;
      mem_rwb   <= 1'b1;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      ready   <= (w_next_state == ST_DONE);
      Hit     <= (w_next_state == ST_DONE) && w_done_hit;
      mem_req <= (w_next_state == ST_MEM_READ) || (w_next_state == ST_MEM_WRITE);
      if ((r_state == ST_IDLE) && req) begin
        r_addr <= Address;
        r_rwb  <= RWB;
        r_data <= Data;
      end
      // Memory command is latched once and held for the whole handshake.
      if (r_state == ST_COMPARE) begin
        r_wr_hit  <= w_hit;
        mem_rwb   <= r_rwb;
        mem_addr  <= r_addr;
        mem_wdata <= r_data;
      end
      if (w_load_out) MemSysOut <= w_out_data;
      if ((w_next_state == ST_DONE) && w_done_hit && (hit_count != 8'hFF)) begin
        hit_count <= hit_count + 8'd1;
      end
    end
  end

endmodule
